// File: rtl/sound_trigger_queue.sv
// Sound trigger queue: edge-detects per-channel start/stop requests, keeps them
// pending, arbitrates stops before starts (lowest channel first) into a small event FIFO.
module sound_trigger_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] trig_in,
  input  logic [15:0] stop_in,
  input  logic        enable,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_stop,
  output logic [3:0]  evt_chan,
  output logic [7:0]  coalesce_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic       stop;
    logic [3:0] chan;
  } evt_t;

  logic [15:0]   trig_q, trig_d;
  logic [15:0]   stop_q, stop_d;
  logic          arm_q, arm_d;
  logic [15:0]   pend_start_q, pend_start_d;
  logic [15:0]   pend_stop_q, pend_stop_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    coal_q, coal_d;
  evt_t          mem_q [DEPTH];

  logic [15:0] trig_edge, stop_edge;
  logic [15:0] clr_start, clr_stop;
  logic        full, push, pop, coal_hit;
  evt_t        push_evt, head;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    push      = 1'b0;
    push_evt  = '0;
    clr_start = '0;
    clr_stop  = '0;

    // arm_q masks the first clock after reset so levels already high are not edges.
    trig_edge = trig_in & ~trig_q & {16{arm_q & enable}};
    stop_edge = stop_in & ~stop_q & {16{arm_q & enable}};

    full = (count_q == FULL_CNT);
    pop  = evt_valid & evt_ready;

    if (enable && !full) begin
      if (|pend_stop_q) begin
        push          = 1'b1;
        push_evt.stop = 1'b1;
        push_evt.chan = lowest_idx(pend_stop_q);
        clr_stop      = 16'd1 << push_evt.chan;
      end else if (|pend_start_q) begin
        push          = 1'b1;
        push_evt.stop = 1'b0;
        push_evt.chan = lowest_idx(pend_start_q);
        clr_start     = 16'd1 << push_evt.chan;
      end
    end

    // Edges are OR-ed in after the clear so a fresh request on the issued bit survives;
    // a stop edge cancels an older start but not one arriving in the same cycle.
    pend_stop_d  = (pend_stop_q & ~clr_stop) | stop_edge;
    pend_start_d = (pend_start_q & ~clr_start & ~stop_edge) | trig_edge;

    coal_hit = |((trig_edge & pend_start_q) | (stop_edge & pend_stop_q));
    coal_d   = coal_q;
    if (coal_hit && coal_q != 8'hFF) coal_d = coal_q + 8'd1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (!enable) begin
      pend_start_d = '0;
      pend_stop_d  = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end

    trig_d = trig_in;
    stop_d = stop_in;
    arm_d  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      trig_q       <= '0;
      stop_q       <= '0;
      arm_q        <= 1'b0;
      pend_start_q <= '0;
      pend_stop_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      coal_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      trig_q       <= trig_d;
      stop_q       <= stop_d;
      arm_q        <= arm_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      coal_q       <= coal_d;
    end
  end

  // NOTE: the storage array has no reset; outputs are gated by evt_valid instead,
  // so stale entries are never visible.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_evt;
  end

  assign head         = mem_q[rd_ptr_q];
  assign evt_valid    = (count_q != '0);
  assign evt_stop     = evt_valid & head.stop;
  assign evt_chan     = evt_valid ? head.chan : 4'd0;
  assign coalesce_cnt = coal_q;

endmodule

// File: tb/tb_sound_trigger_queue.sv
// Directed self-checking bench for sound_trigger_queue (DEPTH=4).
module tb_sound_trigger_queue;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] trig_in;
  logic [15:0] stop_in;
  logic        enable;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_stop;
  logic [3:0]  evt_chan;
  logic [7:0]  coalesce_cnt;

  int n_checks = 0;
  int n_errors = 0;

  sound_trigger_queue #(.DEPTH(4)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .trig_in      (trig_in),
    .stop_in      (stop_in),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_stop     (evt_stop),
    .evt_chan     (evt_chan),
    .coalesce_cnt (coalesce_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic peek(input string tag, input logic s, input logic [3:0] c);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_stop"},  32'(evt_stop),  32'(s));
    check({tag, "_chan"},  32'(evt_chan),  32'(c));
  endtask

  // Check the presented head, then let one clock consume it (evt_ready is 1).
  task automatic exp_head(input string tag, input logic s, input logic [3:0] c);
    peek(tag, s, c);
    tick();
  endtask

  task automatic exp_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_idle"}, 32'(evt_valid), 32'd0);
      tick();
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    trig_in   = 16'h0010;
    stop_in   = 16'h0000;
    enable    = 1'b1;
    evt_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_stop",  32'(evt_stop),  32'd0);
    check("rst_chan",  32'(evt_chan),  32'd0);
    check("rst_coal",  32'(coalesce_cnt), 32'd0);

    // Level already high at reset release must not produce an event.
    RESET_N = 1'b1;
    tick();
    exp_idle("release", 4);
    trig_in = 16'h0000;
    tick();

    // Single start on channel 2, two-clock latency, one beat only.
    trig_in = 16'h0004;
    tick();
    check("t030_lat1", 32'(evt_valid), 32'd0);
    tick();
    exp_head("t030", 1'b0, 4'd2);
    exp_idle("t030", 4);
    trig_in = 16'h0000;
    tick();

    // Simultaneous trig 0,7 and stop 7: stop first, start kept.
    trig_in = 16'h0081;
    stop_in = 16'h0080;
    tick();
    tick();
    exp_head("t031_a", 1'b1, 4'd7);
    exp_head("t031_b", 1'b0, 4'd0);
    exp_head("t031_c", 1'b0, 4'd7);
    exp_idle("t031", 3);
    trig_in = 16'h0000;
    stop_in = 16'h0000;
    tick();

    // FIFO full with ready low: 0..3 queued, 4 and 5 wait, order preserved.
    evt_ready = 1'b0;
    trig_in   = 16'h003F;
    repeat (7) tick();
    peek("t032_hold", 1'b0, 4'd0);
    evt_ready = 1'b1;
    for (int ch = 0; ch < 6; ch++) exp_head("t032", 1'b0, 4'(ch));
    exp_idle("t032", 3);
    trig_in = 16'h0000;
    tick();

    // Channel 3 pending behind a full FIFO while its trig bit toggles.
    evt_ready = 1'b0;
    trig_in   = 16'h0017;
    repeat (6) tick();
    trig_in = 16'h001F; tick();
    trig_in = 16'h0017; tick();
    trig_in = 16'h001F; tick();
    trig_in = 16'h0017; tick();
    trig_in = 16'h001F; tick();
    check("t033_coal", 32'(coalesce_cnt), 32'd2);
    peek("t033_hold", 1'b0, 4'd0);
    evt_ready = 1'b1;
    exp_head("t033_0", 1'b0, 4'd0);
    exp_head("t033_1", 1'b0, 4'd1);
    exp_head("t033_2", 1'b0, 4'd2);
    exp_head("t033_4", 1'b0, 4'd4);
    exp_head("t033_3", 1'b0, 4'd3);
    exp_idle("t033", 4);
    trig_in = 16'h0000;
    tick();
    check("t033_coal_keep", 32'(coalesce_cnt), 32'd2);

    // Stop on channel 9 cancels its unissued start.
    evt_ready = 1'b0;
    trig_in   = 16'h000F;
    repeat (6) tick();
    trig_in = 16'h020F;
    tick();
    stop_in = 16'h0200;
    tick();
    evt_ready = 1'b1;
    for (int ch = 0; ch < 4; ch++) exp_head("t034", 1'b0, 4'(ch));
    exp_head("t034_stop9", 1'b1, 4'd9);
    exp_idle("t034", 5);
    check("t034_coal", 32'(coalesce_cnt), 32'd2);
    trig_in = 16'h0000;
    stop_in = 16'h0000;
    tick();

    // Disable flushes the queue; a level raised while disabled yields no event.
    evt_ready = 1'b0;
    trig_in   = 16'h0007;
    repeat (5) tick();
    peek("t035_q3", 1'b0, 4'd0);
    trig_in = 16'h0000;
    tick();
    enable  = 1'b0;
    trig_in = 16'h0001;
    tick();
    check("t035_flush", 32'(evt_valid), 32'd0);
    enable    = 1'b1;
    evt_ready = 1'b1;
    exp_idle("t035_reen", 5);

    // Asynchronous reset mid-queue clears everything before the next clock.
    trig_in   = 16'h0000;
    tick();
    evt_ready = 1'b0;
    trig_in   = 16'h0400;
    stop_in   = 16'h0800;
    repeat (3) tick();
    peek("t035_pre_rst", 1'b1, 4'd11);
    RESET_N = 1'b0;
    #1;
    check("t035_rst_valid", 32'(evt_valid), 32'd0);
    check("t035_rst_stop",  32'(evt_stop),  32'd0);
    check("t035_rst_chan",  32'(evt_chan),  32'd0);
    check("t035_rst_coal",  32'(coalesce_cnt), 32'd0);
    #1;
    RESET_N = 1'b1;
    tick();
    evt_ready = 1'b1;
    exp_idle("t035_post_rst", 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sound_trigger_queue.md
SOUND_TRIGGER_QUEUE -- requirements
Module: sound_trigger_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock (clk_sys domain).
REQ-003 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port trig_in, input, 16 bits: sound trigger port bits from the game core, where bit n requests a start on channel n.
REQ-005 SHALL have port stop_in, input, 16 bits: sound stop port bits, where bit n requests a stop on channel n.
REQ-006 SHALL have port enable, input, 1 bit: sample playback enabled (samples loaded and not paused).
REQ-007 SHALL have port evt_valid, output, 1 bit: a queued event is presented.
REQ-008 SHALL have port evt_ready, input, 1 bit: the sample player accepts the presented event.
REQ-009 SHALL have port evt_stop, output, 1 bit: 1 means a stop event and 0 means a start event.
REQ-010 SHALL have port evt_chan, output, 4 bits: channel number of the presented event.
REQ-011 SHALL have port coalesce_cnt, output, 8 bits: saturating count of requests merged into an already-pending request.

Function
REQ-012 SHALL register trig_in and stop_in each cycle into trig_q and stop_q, and define edge = in & ~in_q.
REQ-013 SHALL set pending_start[n] on a trig edge and pending_stop[n] on a stop edge, at the same clock edge the input is sampled.
REQ-014 SHALL clear pending_start[n] when a stop edge on channel n is captured, so that a stop cancels an unissued start.
REQ-015 SHALL keep the start pending when trig and stop edges arrive together on channel n, and SHALL issue the stop first.
REQ-016 SHALL increment coalesce_cnt, saturating at 255, for each edge landing on a bit already pending; multiple bits in one cycle count as 1 per cycle.
REQ-017 SHALL run the arbiter each cycle the FIFO is not full:
  - if any pending_stop bit is set, push {stop=1, lowest set index};
  - else if any pending_start bit is set, push {stop=0, lowest set index};
  - clear the pushed bit.
REQ-018 SHALL let a new edge on the bit being cleared in the same cycle win, so the bit stays pending.
REQ-019 SHALL give an edge sampled at clock edge k evt_valid=1 after edge k+1 when the FIFO is empty and no higher-priority bit is pending, for a latency of 2 clocks.
REQ-020 SHALL present the FIFO head combinationally as evt_valid = (count != 0), with evt_stop and evt_chan taken from the head entry.
REQ-021 SHALL pop the head on evt_valid & evt_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-022 SHALL hold the presented event stable while evt_valid=1 and evt_ready=0.
REQ-023 SHALL stall the arbiter when the FIFO is full (count == DEPTH); requests stay pending and are not lost.
REQ-024 SHALL, while enable=0, ignore edges, hold both pending bitmaps at 0, and flush the FIFO (count=0) each cycle.
REQ-025 SHALL keep trig_q and stop_q tracking the inputs while enable=0, so that levels held across a 0->1 enable transition produce no edge.
REQ-026 SHALL clear coalesce_cnt only on reset.

Reset
REQ-027 SHALL, while RESET_N=0, hold trig_q, stop_q, both pending bitmaps, FIFO pointers, count and coalesce_cnt at 0, with evt_valid=0, evt_stop=0 and evt_chan=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard pending and queued events immediately and asynchronously.
REQ-029 SHALL release reset with no event generated for inputs already high at release.

Verification
REQ-030 SHALL cover: enable=1, evt_ready=1, trig_in 0x0000->0x0004 -> two clocks later one beat evt_valid=1, evt_stop=0, evt_chan=2; no further events.
REQ-031 SHALL cover: trig_in 0x0000->0x0081 and stop_in 0x0000->0x0080 in the same cycle -> events in order (stop,7), (start,0), (start,7).
REQ-032 SHALL cover: evt_ready=0, DEPTH=4, rising edges on channels 0..5 -> four events queued, channels 4 and 5 stay pending; raising evt_ready yields channels 0,1,2,3,4,5 in order.
REQ-033 SHALL cover: channel 3 start pending while the FIFO is full, then trig bit 3 toggles 0->1->0->1 -> coalesce_cnt=2 and exactly one (start,3) is issued.
REQ-034 SHALL cover: trig edge on channel 9 then stop edge on channel 9 before the arbiter issues it -> only (stop,9) is issued.
REQ-035 SHALL cover: three events queued then enable=0 for one cycle -> evt_valid=0 the next cycle; trig_in held at 0x0001 across re-enable produces no event; RESET_N pulse low mid-queue -> all outputs 0 immediately.
